nor_equiv_checker: RTL

//   Self-contained hardware equivalence checker for small combinational functions.

---
 rtl/nor_equiv_checker.sv | 112 +++++++++++
 1 files changed

// File: rtl/nor_equiv_checker.sv
// rtl/nor_equiv_checker.sv - exhaustive sweep/compare checker for two combinational implementations
module nor_equiv_checker #(
  parameter int N_IN       = 2,
  parameter int MISMATCH_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [N_IN-1:0]       vec_out,
  input  logic                  res_a,
  input  logic                  res_b,
  output logic                  busy,
  output logic                  done,
  output logic                  equal,
  output logic [MISMATCH_W-1:0] mismatch_count,
  output logic [N_IN-1:0]       first_bad_vec,
  output logic                  first_bad_valid,
  output logic [(1<<N_IN)-1:0]  truth_a
);

  localparam int N_VEC = 1 << N_IN;
  localparam logic [N_IN-1:0]       VEC_LAST = '1;
  localparam logic [N_IN-1:0]       VEC_ONE  = N_IN'(1);
  localparam logic [MISMATCH_W-1:0] CNT_MAX  = '1;
  localparam logic [MISMATCH_W-1:0] CNT_ONE  = MISMATCH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [N_IN-1:0]         vec_q, vec_d;
  logic [MISMATCH_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]         fbv_q, fbv_d;
  logic                    fbvalid_q, fbvalid_d;
  logic [N_VEC-1:0]        truth_q, truth_d;

  // Next-state: start (re)arms a sweep from IDLE or DONE; RUN samples one vector per cycle
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    fbv_d     = fbv_q;
    fbvalid_d = fbvalid_q;
    truth_d   = truth_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          vec_d     = '0;
          cnt_d     = '0;
          fbv_d     = '0;
          fbvalid_d = 1'b0;
          truth_d   = '0;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here so a sweep always runs to completion
        truth_d[vec_q] = res_a;
        if (res_a != res_b) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (!fbvalid_q) begin
            fbv_d     = vec_q;
            fbvalid_d = 1'b1;
          end
        end
        // The last vector stays on vec_out in DONE rather than wrapping to 0
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything immediately, aborting any sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      fbv_q     <= '0;
      fbvalid_q <= 1'b0;
      truth_q   <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      fbv_q     <= fbv_d;
      fbvalid_q <= fbvalid_d;
      truth_q   <= truth_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign equal           = (state_q == S_DONE) && (cnt_q == '0);
  assign mismatch_count  = cnt_q;
  assign first_bad_vec   = fbv_q;
  assign first_bad_valid = fbvalid_q;
  assign truth_a         = truth_q;

endmodule
